// File: rtl/pipelined_control.sv
// Control unit for the 16-bit core: decodes the ID instruction, carries control through
// ID/EX, EX/MEM and MEM/WB, inserts a bubble on load-use hazards and squashes on flush.
module pipelined_control #(
  parameter int INSTR_W    = 16,
  parameter int REG_ADDR_W = 3,
  parameter int RD_LSB     = 2,
  parameter int RS1_LSB    = 8,
  parameter int RS2_LSB    = 11,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [INSTR_W-1:0]    id_instr,
  input  logic                  flush,
  input  logic                  clr_count,
  output logic                  stall,
  output logic                  ex_valid,
  output logic                  ex_alu_src,
  output logic [1:0]            ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_valid,
  output logic                  mem_branch,
  output logic                  mem_mem_write,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_valid,
  output logic                  wb_mem_to_reg,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]      stall_count
);

  typedef struct packed {
    logic                  valid;
    logic                  alu_src;
    logic [1:0]            alu_op;
    logic                  branch;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } ctrl_t;

  // valid marks a real instruction in a stage; stall holds the producer (PC, IF/ID) for one
  // cycle while a bubble (valid=0, all control 0) enters EX in place of the held instruction.
  ctrl_t id_ex_q, ex_mem_q, mem_wb_q;
  ctrl_t dec;

  logic [1:0]            op;
  logic [1:0]            f2;
  logic [REG_ADDR_W-1:0] rd, rs1, rs2;
  logic                  uses_rs2;
  logic                  unused_bits;
  logic [CNT_W-1:0]      cnt_q;

  assign op          = id_instr[1:0];
  assign f2          = id_instr[7:6];
  assign rd          = id_instr[RD_LSB  +: REG_ADDR_W];
  assign rs1         = id_instr[RS1_LSB +: REG_ADDR_W];
  assign rs2         = id_instr[RS2_LSB +: REG_ADDR_W];
  assign uses_rs2    = (op != 2'b01);
  assign unused_bits = ^id_instr;

  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec.rd     = rd;
    dec.alu_op = (op == 2'b01 && f2 == 2'b01) ? 2'b00 : f2;
    case (op)
      2'b00: dec.reg_write = 1'b1;
      2'b01: begin
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = (f2 == 2'b01);
      end
      2'b10: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = (f2 == 2'b00);
      end
      default: dec.branch = 1'b1;
    endcase
    // x0 is hardwired zero, so nothing targeting it may write back
    if (rd == '0) begin
      dec.reg_write  = 1'b0;
      dec.mem_to_reg = 1'b0;
    end
  end

  always_comb begin
    stall = id_valid & id_ex_q.valid & id_ex_q.mem_to_reg &
            ((id_ex_q.rd == rs1) | (uses_rs2 & (id_ex_q.rd == rs2))) & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      mem_wb_q <= ex_mem_q;
      ex_mem_q <= flush ? '0 : id_ex_q;
      id_ex_q  <= (flush || stall || !id_valid) ? '0 : dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_count) begin
      cnt_q <= '0;
    end else if (stall && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ex_valid      = id_ex_q.valid;
  assign ex_alu_src    = id_ex_q.alu_src;
  assign ex_alu_op     = id_ex_q.alu_op;
  assign ex_rd         = id_ex_q.rd;
  assign mem_valid     = ex_mem_q.valid;
  assign mem_branch    = ex_mem_q.branch;
  assign mem_mem_write = ex_mem_q.mem_write;
  assign mem_rd        = ex_mem_q.rd;
  assign wb_valid      = mem_wb_q.valid;
  assign wb_mem_to_reg = mem_wb_q.mem_to_reg;
  assign wb_reg_write  = mem_wb_q.reg_write;
  assign wb_rd         = mem_wb_q.rd;
  assign stall_count   = cnt_q;

endmodule

// File: tb/tb_pipelined_control.sv
// Bench for pipelined_control: scoreboarded decode/hazard sequences plus flush, counter
// saturation (second instance with a 2-bit counter) and asynchronous reset scenarios.
module tb_pipelined_control;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [15:0] id_instr;
  logic        flush;
  logic        clr_count;

  logic        stall, ex_valid, ex_alu_src, mem_valid, mem_branch, mem_mem_write;
  logic        wb_valid, wb_mem_to_reg, wb_reg_write;
  logic [1:0]  ex_alu_op;
  logic [2:0]  ex_rd, mem_rd, wb_rd;
  logic [15:0] stall_count;

  logic        c2_stall, c2_ex_valid, c2_ex_alu_src, c2_mem_valid, c2_mem_branch;
  logic        c2_mem_mem_write, c2_wb_valid, c2_wb_mem_to_reg, c2_wb_reg_write;
  logic [1:0]  c2_ex_alu_op;
  logic [2:0]  c2_ex_rd, c2_mem_rd, c2_wb_rd;
  logic [1:0]  c2_stall_count;

  logic [7:0]  exp_ex_q[$];
  logic [7:0]  exp_mem_q[$];
  logic [7:0]  exp_wb_q[$];
  logic [7:0]  ex_word, mem_word, wb_word, exp_v;
  int          checks;
  int          failures;
  int          cnt_exp;

  assign ex_word  = {1'b0, ex_valid, ex_alu_src, ex_alu_op, ex_rd};
  assign mem_word = {2'b0, mem_valid, mem_branch, mem_mem_write, mem_rd};
  assign wb_word  = {2'b0, wb_valid, wb_mem_to_reg, wb_reg_write, wb_rd};

  pipelined_control dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .flush(flush),
    .clr_count(clr_count), .stall(stall), .ex_valid(ex_valid), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_branch(mem_branch),
    .mem_mem_write(mem_mem_write), .mem_rd(mem_rd), .wb_valid(wb_valid),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .stall_count(stall_count)
  );

  pipelined_control #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .flush(flush),
    .clr_count(clr_count), .stall(c2_stall), .ex_valid(c2_ex_valid),
    .ex_alu_src(c2_ex_alu_src), .ex_alu_op(c2_ex_alu_op), .ex_rd(c2_ex_rd),
    .mem_valid(c2_mem_valid), .mem_branch(c2_mem_branch), .mem_mem_write(c2_mem_mem_write),
    .mem_rd(c2_mem_rd), .wb_valid(c2_wb_valid), .wb_mem_to_reg(c2_wb_mem_to_reg),
    .wb_reg_write(c2_wb_reg_write), .wb_rd(c2_wb_rd), .stall_count(c2_stall_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [1:0] op, input logic [1:0] f2,
                                     input logic [2:0] rd, input logic [2:0] rs1,
                                     input logic [2:0] rs2);
    return {2'b00, rs2, rs1, f2, 1'b0, rd, op};
  endfunction

  function automatic logic [7:0] ex_e(input logic v, input logic src, input logic [1:0] aop,
                                      input logic [2:0] rd);
    return {1'b0, v, src, aop, rd};
  endfunction

  function automatic logic [7:0] mem_e(input logic v, input logic br, input logic mw,
                                       input logic [2:0] rd);
    return {2'b0, v, br, mw, rd};
  endfunction

  function automatic logic [7:0] wb_e(input logic v, input logic m2r, input logic rw,
                                      input logic [2:0] rd);
    return {2'b0, v, m2r, rw, rd};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    flush    = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_seq();
    exp_ex_q.delete();
    exp_mem_q.delete();
    exp_wb_q.delete();
    exp_mem_q.push_back(8'h00);
    exp_wb_q.push_back(8'h00);
    exp_wb_q.push_back(8'h00);
  endtask

  // scoreboard: expectations pushed at drive time, popped one per stage per cycle
  task automatic issue(input logic v, input logic [15:0] ins, input logic exp_st,
                       input logic [7:0] e_ex, input logic [7:0] e_mem,
                       input logic [7:0] e_wb);
    id_valid = v;
    id_instr = ins;
    flush    = 1'b0;
    exp_ex_q.push_back(e_ex);
    exp_mem_q.push_back(e_mem);
    exp_wb_q.push_back(e_wb);
    #1;
    checks++;
    if (stall !== exp_st) begin
      failures++;
      $display("FAIL stall instr=%h got=%b want=%b", ins, stall, exp_st);
    end
    if (exp_st) cnt_exp++;
    step();
    exp_v = exp_ex_q.pop_front();
    checks++;
    if (ex_word !== exp_v) begin
      failures++;
      $display("FAIL ex_stage got=%h want=%h", ex_word, exp_v);
    end
    exp_v = exp_mem_q.pop_front();
    checks++;
    if (mem_word !== exp_v) begin
      failures++;
      $display("FAIL mem_stage got=%h want=%h", mem_word, exp_v);
    end
    exp_v = exp_wb_q.pop_front();
    checks++;
    if (wb_word !== exp_v) begin
      failures++;
      $display("FAIL wb_stage got=%h want=%h", wb_word, exp_v);
    end
  endtask

  task automatic end_seq();
    issue(1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 8'h00);
    issue(1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; flush = 1'b0; clr_count = 1'b0;
    cnt_exp = 0;
    #2;
    checks++;
    if ({ex_word, mem_word, wb_word, stall_count, stall} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h_%h_%h cnt=%0d", ex_word, mem_word, wb_word,
               stall_count);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_decode();
    start_seq();
    issue(1'b1, mk(2'b00, 2'b10, 3'd3, 3'd1, 3'd4), 1'b0,
          ex_e(1, 0, 2'b10, 3'd3), mem_e(1, 0, 0, 3'd3), wb_e(1, 0, 1, 3'd3));
    issue(1'b1, mk(2'b01, 2'b01, 3'd2, 3'd1, 3'd0), 1'b0,
          ex_e(1, 1, 2'b00, 3'd2), mem_e(1, 0, 0, 3'd2), wb_e(1, 1, 1, 3'd2));
    issue(1'b1, mk(2'b10, 2'b00, 3'd0, 3'd1, 3'd5), 1'b0,
          ex_e(1, 1, 2'b00, 3'd0), mem_e(1, 0, 1, 3'd0), wb_e(1, 0, 0, 3'd0));
    issue(1'b1, mk(2'b11, 2'b11, 3'd0, 3'd6, 3'd7), 1'b0,
          ex_e(1, 0, 2'b11, 3'd0), mem_e(1, 1, 0, 3'd0), wb_e(1, 0, 0, 3'd0));
    issue(1'b1, mk(2'b01, 2'b10, 3'd5, 3'd3, 3'd0), 1'b0,
          ex_e(1, 1, 2'b10, 3'd5), mem_e(1, 0, 0, 3'd5), wb_e(1, 0, 1, 3'd5));
    end_seq();
  endtask

  task automatic test_x0();
    start_seq();
    issue(1'b1, mk(2'b00, 2'b01, 3'd0, 3'd1, 3'd2), 1'b0,
          ex_e(1, 0, 2'b01, 3'd0), mem_e(1, 0, 0, 3'd0), wb_e(1, 0, 0, 3'd0));
    end_seq();
  endtask

  task automatic load_use_pair(input logic [15:0] user, input logic exp_st,
                               input logic [7:0] u_ex, input logic [7:0] u_mem,
                               input logic [7:0] u_wb);
    issue(1'b1, mk(2'b01, 2'b01, 3'd2, 3'd1, 3'd0), 1'b0,
          ex_e(1, 1, 2'b00, 3'd2), mem_e(1, 0, 0, 3'd2), wb_e(1, 1, 1, 3'd2));
    if (exp_st) issue(1'b1, user, 1'b1, 8'h00, 8'h00, 8'h00);
    issue(1'b1, user, 1'b0, u_ex, u_mem, u_wb);
  endtask

  task automatic test_load_use();
    start_seq();
    load_use_pair(mk(2'b00, 2'b00, 3'd4, 3'd3, 3'd2), 1'b1,
                  ex_e(1, 0, 2'b00, 3'd4), mem_e(1, 0, 0, 3'd4), wb_e(1, 0, 1, 3'd4));
    checks++;
    if (stall_count !== 16'(cnt_exp)) begin
      failures++;
      $display("FAIL load_use_count got=%0d want=%0d", stall_count, cnt_exp);
    end
    load_use_pair(mk(2'b01, 2'b00, 3'd4, 3'd3, 3'd2), 1'b0,
                  ex_e(1, 1, 2'b00, 3'd4), mem_e(1, 0, 0, 3'd4), wb_e(1, 0, 1, 3'd4));
    end_seq();
  endtask

  task automatic test_flush();
    id_valid = 1'b1;
    id_instr = mk(2'b01, 2'b01, 3'd2, 3'd1, 3'd0);
    step();
    id_instr = mk(2'b00, 2'b00, 3'd4, 3'd3, 3'd2);
    flush    = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall got=%b want=0", stall);
    end
    step();
    checks++;
    if ({ex_valid, mem_valid} !== 2'b00) begin
      failures++;
      $display("FAIL flush_squash got ex=%b mem=%b want 0 0", ex_valid, mem_valid);
    end
    checks++;
    if (stall_count !== 16'(cnt_exp)) begin
      failures++;
      $display("FAIL flush_count got=%0d want=%0d", stall_count, cnt_exp);
    end
    idle(3);
  endtask

  task automatic test_counter();
    logic [15:0] user;
    user = mk(2'b00, 2'b00, 3'd4, 3'd2, 3'd3);
    clr_count = 1'b1;
    idle(1);
    clr_count = 1'b0;
    cnt_exp = 0;
    checks++;
    if ({stall_count, c2_stall_count} !== 18'd0) begin
      failures++;
      $display("FAIL count_clear got=%0d/%0d want=0/0", stall_count, c2_stall_count);
    end
    start_seq();
    for (int i = 0; i < 5; i++)
      load_use_pair(user, 1'b1, ex_e(1, 0, 2'b00, 3'd4), mem_e(1, 0, 0, 3'd4),
                    wb_e(1, 0, 1, 3'd4));
    checks++;
    if (stall_count !== 16'(cnt_exp)) begin
      failures++;
      $display("FAIL count_five got=%0d want=%0d", stall_count, cnt_exp);
    end
    checks++;
    if (c2_stall_count !== 2'd3) begin
      failures++;
      $display("FAIL count_saturate got=%0d want=3", c2_stall_count);
    end
    issue(1'b1, mk(2'b01, 2'b01, 3'd2, 3'd1, 3'd0), 1'b0,
          ex_e(1, 1, 2'b00, 3'd2), mem_e(1, 0, 0, 3'd2), wb_e(1, 1, 1, 3'd2));
    clr_count = 1'b1;
    issue(1'b1, user, 1'b1, 8'h00, 8'h00, 8'h00);
    clr_count = 1'b0;
    cnt_exp = 0;
    checks++;
    if ({stall_count, c2_stall_count} !== 18'd0) begin
      failures++;
      $display("FAIL count_clr_priority got=%0d/%0d want=0/0", stall_count, c2_stall_count);
    end
    issue(1'b1, user, 1'b0, ex_e(1, 0, 2'b00, 3'd4), mem_e(1, 0, 0, 3'd4),
          wb_e(1, 0, 1, 3'd4));
    end_seq();
  endtask

  task automatic test_reset_mid();
    id_valid = 1'b1;
    id_instr = mk(2'b01, 2'b01, 3'd2, 3'd1, 3'd0);
    step();
    id_instr = mk(2'b00, 2'b00, 3'd4, 3'd2, 3'd3);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre_stall got=%b want=1", stall);
    end
    step();
    checks++;
    if (stall_count !== 16'(cnt_exp + 1)) begin
      failures++;
      $display("FAIL reset_mid_pre_count got=%0d want=%0d", stall_count, cnt_exp + 1);
    end
    id_instr = mk(2'b01, 2'b01, 3'd2, 3'd1, 3'd0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ex_word, mem_word, wb_word, stall_count, stall} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h_%h_%h cnt=%0d stall=%b", ex_word, mem_word,
               wb_word, stall_count, stall);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    id_valid = 1'b0;
    cnt_exp = 0;
    step();
    checks++;
    if ({stall_count, c2_stall_count, ex_valid} !== 19'd0) begin
      failures++;
      $display("FAIL reset_mid_release got cnt=%0d/%0d ex_valid=%b want 0", stall_count,
               c2_stall_count, ex_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_decode();
    test_x0();
    test_load_use();
    test_flush();
    test_counter();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
